// File: rtl/vga_framebuffer.sv
// 160x120x3 framebuffer with a write port for the drawing engines and a VGA
// scan-out that shows each stored pixel as a 4x4 block (640x480 @ 60 Hz at default timing).
module vga_framebuffer #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       writeEn,
  output logic       vga_clk,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vblank
);

  localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FB_DEPTH = 19200;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_L = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);

  logic       r_tick;
  logic       r_run;
  logic [9:0] r_h_count;
  logic [9:0] r_v_count;
  logic       r_vblank;
  logic [2:0] r_mem [0:FB_DEPTH-1];
  logic [2:0] r_rd_data;
  logic       r_hs1;
  logic       r_vs1;
  logic       r_vis1;

  logic [9:0]  w_h_next;
  logic [9:0]  w_v_next;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_vis_raw;
  logic        w_wr_ok;
  logic [14:0] w_wr_addr;
  logic [14:0] w_rd_addr;
  logic [14:0] w_row_base;

  function automatic logic [7:0] expand(input logic b);
    return b ? 8'hFF : 8'h00;
  endfunction

  assign vga_clk    = r_tick;
  assign vga_sync_n = 1'b0;
  assign vblank     = r_vblank;

  // Next scan position: h wraps at end of line and carries into v.
  always_comb begin
    w_h_next = r_h_count;
    w_v_next = r_v_count;
    if (r_h_count == H_LAST) begin
      w_h_next = 10'd0;
      if (r_v_count == V_LAST) begin
        w_v_next = 10'd0;
      end else begin
        w_v_next = r_v_count + 10'd1;
      end
    end else begin
      w_h_next = r_h_count + 10'd1;
    end
  end

  // Stage 0 decode: raw sync/visible flags and the framebuffer read address.
  always_comb begin
    w_vis_raw  = (r_h_count < H_VIS_L) && (r_v_count < V_VIS_L);
    w_hs_raw   = !((r_h_count >= HS_BEG) && (r_h_count < HS_END));
    w_vs_raw   = !((r_v_count >= VS_BEG) && (r_v_count < VS_END));
    w_row_base = {7'd0, r_v_count[9:2]};
    w_rd_addr  = 15'd0;
    if (w_vis_raw) begin
      w_rd_addr = (w_row_base << 7) + (w_row_base << 5) + {7'd0, r_h_count[9:2]};
    end else begin
      w_rd_addr = 15'd0;
    end
  end

  // Write port: row*160 + col as two shifts; off-screen coordinates are dropped.
  always_comb begin
    w_wr_ok   = r_run && writeEn && (x < 8'd160) && (y < 7'd120);
    w_wr_addr = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
  end

  // Framebuffer RAM (not reset); read-before-write on address collisions.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_addr] <= colour;
    end
    if (r_tick) begin
      r_rd_data <= r_mem[w_rd_addr];
    end
  end

  // Write gate: held off while reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Pixel tick, scan counters and the two-stage sync/blank/colour pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick      <= 1'b0;
      r_h_count   <= 10'd0;
      r_v_count   <= 10'd0;
      r_vblank    <= 1'b0;
      r_hs1       <= 1'b1;
      r_vs1       <= 1'b1;
      r_vis1      <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
    end else begin
      r_tick <= ~r_tick;
      if (r_tick) begin
        r_h_count   <= w_h_next;
        r_v_count   <= w_v_next;
        r_vblank    <= (w_v_next >= V_VIS_L);
        r_hs1       <= w_hs_raw;
        r_vs1       <= w_vs_raw;
        r_vis1      <= w_vis_raw;
        vga_hs      <= r_hs1;
        vga_vs      <= r_vs1;
        vga_blank_n <= r_vis1;
        vga_r       <= r_vis1 ? expand(r_rd_data[2]) : 8'h00;
        vga_g       <= r_vis1 ? expand(r_rd_data[1]) : 8'h00;
        vga_b       <= r_vis1 ? expand(r_rd_data[0]) : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_vga_framebuffer.sv
// Directed bench for vga_framebuffer using a shrunken raster (80 ticks x 62 lines)
// so several frames fit in a short run; visible window covers framebuffer x 0..15, y 0..13.
module tb_vga_framebuffer;

  localparam int HT = 80;
  localparam int VT = 62;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] x = 8'd0;
  logic [6:0] y = 7'd0;
  logic [2:0] colour = 3'd0;
  logic       writeEn = 1'b0;
  logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vblank;
  logic [7:0] vga_r, vga_g, vga_b;

  int total = 0;
  int bad = 0;
  int cyc;

  vga_framebuffer #(
    .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(56), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vblank(vblank)
  );

  always #5 clk = ~clk;

  // clk edges since reset release; edge n leaves scan position floor(n/2)
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rgb(input logic [2:0] c);
    return {8'h00, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Output for scan position P is valid after clk edge 2P+4
  task automatic pix(input string tag, input int fr, input int h, input int v, input logic [2:0] c);
    at(2 * (fr * FT + v * HT + h) + 4);
    chk(tag, {8'h00, vga_r, vga_g, vga_b}, rgb(c));
  endtask

  task automatic wr(input int xx, input int yy, input logic [2:0] c);
    x = 8'(xx);
    y = 7'(yy);
    colour = c;
    writeEn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_clk",   32'(vga_clk), 32'd0);
    chk("rst_hs",    32'(vga_hs), 32'd1);
    chk("rst_vs",    32'(vga_vs), 32'd1);
    chk("rst_blank", 32'(vga_blank_n), 32'd0);
    chk("sync_n",    32'(vga_sync_n), 32'd0);
    chk("rst_rgb",   {8'h00, vga_r, vga_g, vga_b}, 32'd0);
    chk("rst_vblk",  32'(vblank), 32'd0);
    reset = 1'b1;

    at(1);   chk("clk_hi", 32'(vga_clk), 32'd1);
    at(2);   chk("clk_lo", 32'(vga_clk), 32'd0);
    at(3);   chk("blank_pre", 32'(vga_blank_n), 32'd0);
    at(4);   chk("blank_on", 32'(vga_blank_n), 32'd1);
    at(131); chk("blank_last", 32'(vga_blank_n), 32'd1);
    at(132); chk("blank_off", 32'(vga_blank_n), 32'd0);
    chk("blank_rgb0", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
    at(139); chk("hs_pre", 32'(vga_hs), 32'd1);
    at(140); chk("hs_fall", 32'(vga_hs), 32'd0);
    at(155); chk("hs_lowend", 32'(vga_hs), 32'd0);
    at(156); chk("hs_rise", 32'(vga_hs), 32'd1);
    at(163); chk("blank_l1pre", 32'(vga_blank_n), 32'd0);
    at(164); chk("blank_l1on", 32'(vga_blank_n), 32'd1);
    at(299); chk("hs2_pre", 32'(vga_hs), 32'd1);
    at(300); chk("hs2_fall", 32'(vga_hs), 32'd0);

    for (int j = 0; j < 14; j++)
      for (int i = 0; i < 16; i++)
        wr(i, j, 3'd0);
    wr(0, 0, 3'b100);
    wr(15, 13, 3'b011);
    wr(160, 0, 3'b111);
    wr(0, 120, 3'b111);
    for (int j = 0; j < 12; j++)
      for (int i = 0; i < 12; i++)
        wr(4 + i, 1 + j, 3'((i + 3 * j) % 8));
    writeEn = 1'b0;

    at(8959); chk("vblk_pre", 32'(vblank), 32'd0);
    at(8960); chk("vblk_on", 32'(vblank), 32'd1);
    at(9283); chk("vs_pre", 32'(vga_vs), 32'd1);
    at(9284); chk("vs_fall", 32'(vga_vs), 32'd0);
    at(9603); chk("vs_lowend", 32'(vga_vs), 32'd0);
    at(9604); chk("vs_rise", 32'(vga_vs), 32'd1);
    at(9919); chk("vblk_last", 32'(vblank), 32'd1);
    at(9920); chk("vblk_off", 32'(vblank), 32'd0);

    pix("c00", 1, 0, 0, 3'b100);
    pix("c40", 1, 4, 0, 3'b000);
    pix("c33", 1, 3, 3, 3'b100);
    pix("oor_alias", 1, 0, 4, 3'b000);
    pix("glyph_left", 1, 15, 4, 3'b000);
    for (int j = 0; j < 12; j++)
      for (int i = 0; i < 12; i++)
        pix("glyph", 1, 4 * (4 + i) + (i % 4), 4 * (1 + j) + (j % 4), 3'((i + 3 * j) % 8));

    at(2 * (FT + 52 * HT + 8) + 1);
    wr(2, 13, 3'b101);
    writeEn = 1'b0;
    pix("rbw_old", 1, 8, 52, 3'b000);
    pix("rbw_next", 1, 9, 52, 3'b101);
    pix("cyan_a", 1, 60, 52, 3'b011);
    pix("cyan_left", 1, 59, 55, 3'b000);
    pix("cyan_b", 1, 63, 55, 3'b011);
    at(19203); chk("vs2_pre", 32'(vga_vs), 32'd1);
    at(19204); chk("vs2_fall", 32'(vga_vs), 32'd0);
    pix("rbw_f2", 2, 8, 52, 3'b101);

    at(2 * (3 * FT + HT + 2) + 5);
    chk("mid_rgb", {8'h00, vga_r, vga_g, vga_b}, rgb(3'b100));
    chk("mid_clk", 32'(vga_clk), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_clk", 32'(vga_clk), 32'd0);
    chk("arst_hs", 32'(vga_hs), 32'd1);
    chk("arst_vs", 32'(vga_vs), 32'd1);
    chk("arst_blank", 32'(vga_blank_n), 32'd0);
    chk("arst_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
    chk("arst_vblk", 32'(vblank), 32'd0);
    x = 8'd1;
    y = 7'd0;
    colour = 3'b111;
    writeEn = 1'b1;
    repeat (4) @(negedge clk);
    writeEn = 1'b0;
    reset = 1'b1;

    pix("post_c00", 0, 0, 0, 3'b100);
    pix("post_wr_ign", 0, 4, 0, 3'b000);
    at(139); chk("post_hs_pre", 32'(vga_hs), 32'd1);
    at(140); chk("post_hs_fall", 32'(vga_hs), 32'd0);
    pix("post_glyph", 0, 21, 14, 3'b111);
    pix("post_rbw", 0, 8, 52, 3'b101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_framebuffer.md
# vga_framebuffer

Pixel sink for the drawing engines: accepts the single-cycle pixel writes (x, y, colour, writeEn) produced by the note-drawing FSM and stores them in a 160x120, 3-bit-per-pixel framebuffer. It continuously scans the framebuffer out as a 640x480 @ 60 Hz VGA signal, replicating each stored pixel into a 4x4 block. It sits between the drawing logic and the board DAC pins.

## Interface
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- clk  input  1  50 MHz system clock; the only clock
- reset  input  1  asynchronous, active-low reset
- x  input  8  write column, 0..159
- y  input  7  write row, 0..119
- colour  input  3  {R,G,B} write data
- writeEn  input  1  write strobe, one pixel per clk cycle while high
- vga_clk  output  1  clk/2 pixel clock to DAC
- vga_hs  output  1  hsync, active-low
- vga_vs  output  1  vsync, active-low
- vga_blank_n  output  1  high during visible region
- vga_sync_n  output  1  tied 0 (no sync-on-green)
- vga_r, vga_g, vga_b  output  8 each  colour bit expanded to 8'hFF / 8'h00
- vblank  output  1  high while vertical line counter >= V_VIS (safe drawing window)

## Operation
- Storage: 19200 x 3-bit simple dual-port RAM; one write port, one read port, both on clk.
- Write address = y*160 + x, computed as (y<<7)+(y<<5)+x, 15 bits.
- Write occurs on the clk edge where writeEn=1 and x<160 and y<120; out-of-range writes are dropped silently and must not alias.
- Writes are accepted every clk cycle regardless of scan position; there is no back-pressure.
- Pixel tick: internal toggle `tick` at clk/2; vga_clk = tick register. All scan counters advance only on cycles where tick=1.
- h_count 0..H_total-1 (800); v_count 0..V_total-1 (525). h_count wraps to 0 and v_count increments; v_count wraps to 0 after 524.
- Read address = (v_count>>2)*160 + (h_count>>2), only meaningful when h_count<640 and v_count<480.
- hs_raw low for h_count 656..751; vs_raw low for v_count 490..491; vis_raw = h_count<640 && v_count<480.
- RAM contents are not affected by reset; the clear-screen pass is the drawing engine's job.
- Simultaneous read and write to the same address: read returns the old data (read-before-write); the new colour appears on the next frame.

## Timing
- Pipeline, in pixel ticks: stage 0 counters/address; stage 1 RAM read data plus delayed hs/vs/vis; stage 2 registered outputs.
- vga_hs, vga_vs, vga_blank_n and vga_r/g/b are all stage-2 registers, so sync, blank and colour stay mutually aligned with 2-tick latency from the counters.
- During blank (vis=0), vga_r/g/b = 0 regardless of RAM data.
- vblank is derived directly from v_count, with no pipeline delay.
- Reset (asynchronous assert, synchronous release): h_count=0, v_count=0, tick=0, vga_clk=0, vga_hs=1, vga_vs=1, vga_blank_n=0, rgb=0, vblank=0.
- Reset mid-frame restarts the scan at (0,0) on the first tick after release; writes during reset are ignored.
- Write-to-display latency is at most one frame (16.8 ms).

## Test plan
- Reset then free-run: vga_hs period = 1600 clk cycles with a 192-clk low pulse; vga_vs period = 525 lines with a 2-line low pulse; vga_blank_n high for 1280 clk per visible line.
- Write (x=0,y=0,colour=3'b100) and (x=159,y=119,colour=3'b011): the first 4 visible ticks of lines 0-3 show r=FF,g=00,b=00; the last 4 ticks of lines 476-479 show r=00,g=FF,b=FF; all other pixels are 0.
- Write x=160,y=0 and x=0,y=120 with colour 3'b111: no visible pixel changes; address 0 stays unchanged.
- Burst of 144 consecutive writeEn cycles drawing a 12x12 glyph at (20,30): scan-out shows the exact 48x48 replicated pattern at pixel (80,120).
- Assert reset mid-line (h_count~300): outputs take their reset values immediately and asynchronously; after release the first hs falling edge occurs 656 ticks + 2 ticks later; RAM image is preserved.
- Write (5,5) while the scan reads the same address: the current frame shows the old colour and the next frame shows the new colour.
